conv11_win_feeder: RTL
======================

Name: conv11_win_feeder

Overview:
Initiator side of the 3x3 conv calc handshake. Accepts a row-major pixel stream for one IMG_W x IMG_H feature map and builds 3x3 windows (valid convolution, no padding) using two line buffers. For each complete window it drives the window onto the calc data inputs, pulses start for one cycle, and holds both until the calc returns done. Pixel intake stalls while a window is in flight.

Parameters:
DATA_WIDTH, 8, pixel width, signed; must match the calc block
IMG_W, 28, pixels per row, >= 3
IMG_H, 28, rows per frame, >= 3

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
pix_valid  in  1  pixel stream valid
pix_ready  out  1  pixel stream ready
pix_data  in  DATA_WIDTH  signed pixel
calc_start  out  1  one-cycle start to the calc block
calc_done  in  1  calc completion (calc valid_out AND consumer ready)
win_data  out  9*DATA_WIDTH  window; slice k = data_{k/3}_{k%3}, k=0 in LSBs, row 0 = oldest row
frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (rst_n low, async): state FILL, row=col=0, window regs 0, calc_start=0, frame_done=0, pix_ready=0. Line buffer contents need no reset and are never read before being written in the current frame.
- Accept: pix_valid AND pix_ready at a rising edge. pix_ready = (state==FILL) AND rst_n. There is no combinational path from pix_valid to pix_ready.
- On accept at (row,col): new column = {lb1[col], lb0[col], pix_data} (top..bottom). Window columns shift left (c0<=c1, c1<=c2, c2<=new). Then lb1[col]<=lb0[col] and lb0[col]<=pix_data.
- col increments and wraps at IMG_W-1 to 0, then row increments. After (IMG_H-1, IMG_W-1), both counters return to 0.
- A window is complete when row>=2 AND col>=2, evaluated on the accepted pixel's coordinates.
- FSM:
  - FILL: on accept, go to ISSUE if the window is complete, otherwise stay in FILL.
  - ISSUE: calc_start=1 for exactly this cycle, then go to WAIT unconditionally.
  - WAIT: pix_ready=0. On calc_done go to FILL. calc_done seen in FILL or ISSUE is ignored.
- Latency: the accept edge at cycle t gives calc_start high in cycle t+1. win_data is valid from t+1 and held stable until the edge where WAIT exits on calc_done.
- Throughput: with calc_done arriving in the cycle after start (ready_in=1), one window every 3 cycles.
- frame_done: registered pulse in the cycle after the frame's final event. The final event is the calc_done of the last window, or the accept edge of the last pixel if that pixel issues no window.
- Row wrap: the window shift register is not cleared at row start. The col>=2 rule discards stale columns.
- Reset mid-operation: returns to FILL at row 0, col 0, drops any in-flight window and never asserts calc_start spuriously.
- Arithmetic: none on data. row and col counters use $clog2 widths.

Optional Feature:
CONV11_STRIDE2_EN
- Defined: a window is complete only when row>=2, col>=2, (row-2) is even and (col-2) is even. This gives stride 2, with output size floor((IMG_W-3)/2+1) x floor((IMG_H-3)/2+1).
- Undefined: stride 1 as above.
- Pixel intake, line buffers and the frame_done rule are identical in both builds.

Test Plan:
1. IMG_W=IMG_H=4, pixel = row*4+col, calc_done 1 cycle after start -> 4 windows in order. First window (row 0..2) = {0,1,2;4,5,6;8,9,10}. Last = {5,6,7;9,10,11;13,14,15}. frame_done pulses exactly once.
2. Row wrap, same stimulus -> third window = {4,5,6;8,9,10;12,13,14}. No window issues at accepted (3,0) or (3,1).
3. Delay calc_done 6 cycles after start -> pix_ready=0 and win_data constant throughout WAIT. calc_start is a single-cycle pulse. Extra calc_done pulses in FILL cause no effect.
4. pix_valid toggled randomly, two back-to-back frames -> second frame windows match the first-frame expected values. The counter restarts at 0.
5. Deassert rst_n for 1 cycle while in WAIT on window 2 -> outputs return to reset values immediately. A new full frame then yields 4 correct windows.
6. CONV11_STRIDE2_EN, IMG_W=IMG_H=5 -> 4 windows, top-left at (0,0),(0,2),(2,0),(2,2). frame_done follows the calc_done of window 4.

Source files
------------

// File: rtl/conv11_win_feeder.sv
// conv11_win_feeder: builds 3x3 windows from a pixel stream and hands each to the calc block; CONV11_STRIDE2_EN selects stride 2
module conv11_win_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         pix_valid,
    output logic                         pix_ready,
    input  logic signed [DATA_WIDTH-1:0] pix_data,
    output logic                         calc_start,
    input  logic                         calc_done,
    output logic [9*DATA_WIDTH-1:0]      win_data,
    output logic                         frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    typedef enum logic [1:0] {FILL, ISSUE, WAIT} state_t;
    state_t                r_state;
    logic [CW-1:0]         r_col;
    logic [RW-1:0]         r_row;
    logic [DATA_WIDTH-1:0] r_lb0 [IMG_W];
    logic [DATA_WIDTH-1:0] r_lb1 [IMG_W];
    logic [DATA_WIDTH-1:0] r_win [3][3];
    logic                  r_start;
    logic                  r_frame_done;
    logic                  r_last_win;
    logic                  w_accept;
    logic                  w_last;
    logic                  w_complete;
    assign pix_ready  = (r_state == FILL) && rst_n;
    assign w_accept   = pix_valid && pix_ready;
    assign w_last     = (r_row == ROW_LAST) && (r_col == COL_LAST);
`ifdef CONV11_STRIDE2_EN
    assign w_complete = (r_row >= RW'(2)) && (r_col >= CW'(2)) && !r_row[0] && !r_col[0];
`else
    assign w_complete = (r_row >= RW'(2)) && (r_col >= CW'(2));
`endif
    assign calc_start = r_start;
    assign frame_done = r_frame_done;
    for (genvar k = 0; k < 9; k++) begin : g_win
        assign win_data[k*DATA_WIDTH +: DATA_WIDTH] = r_win[k/3][k%3];
    end
    // line buffers hold the two previous rows; never read before written in a frame, so no reset
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb1[r_col] <= r_lb0[r_col];
            r_lb0[r_col] <= pix_data;
        end
    end
    // position counters and window column shift advance on every accepted pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row <= '0;
            r_col <= '0;
            r_win <= '{default: '0};
        end else if (w_accept) begin
            r_col <= (r_col == COL_LAST) ? '0 : r_col + 1'b1;
            if (r_col == COL_LAST)
                r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
            for (int r = 0; r < 3; r++) begin
                r_win[r][0] <= r_win[r][1];
                r_win[r][1] <= r_win[r][2];
            end
            r_win[0][2] <= r_lb1[r_col];
            r_win[1][2] <= r_lb0[r_col];
            r_win[2][2] <= pix_data;
        end
    end
    // handshake FSM with registered start and end-of-frame pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= FILL;
            r_start      <= 1'b0;
            r_frame_done <= 1'b0;
            r_last_win   <= 1'b0;
        end else begin
            r_start      <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                FILL: if (w_accept) begin
                    if (w_complete) begin
                        r_state    <= ISSUE;
                        r_start    <= 1'b1;
                        r_last_win <= w_last;
                    end else if (w_last) begin
                        r_frame_done <= 1'b1;
                    end
                end
                ISSUE: r_state <= WAIT;
                WAIT: if (calc_done) begin
                    r_state      <= FILL;
                    r_frame_done <= r_last_win;
                end
                default: r_state <= FILL;
            endcase
        end
    end
endmodule
